// File: rtl/kt_pkg.sv
// Shared definitions for the multi-channel kitchen timer.
// Contents: command opcodes, channel state encoding and the seconds limit.
package kt_pkg;

   // Command opcodes carried on cmd_op
   localparam logic [2:0] OP_NOP     = 3'd0;
   localparam logic [2:0] OP_LD_MIN  = 3'd1;
   localparam logic [2:0] OP_LD_SEC  = 3'd2;
   localparam logic [2:0] OP_START   = 3'd3;
   localparam logic [2:0] OP_PAUSE   = 3'd4;
   localparam logic [2:0] OP_RESUME  = 3'd5;
   localparam logic [2:0] OP_CLEAR   = 3'd6;
   localparam logic [2:0] OP_SET_DIR = 3'd7;

   localparam logic [6:0] SEC_MAX = 7'd59;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_ALARM  = 2'd3
   } kt_state_t;

endpackage

// File: rtl/kt_channel.sv
// One timer channel: control FSM, mm:ss up/down counter and alarm auto-clear.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   cmd_valid      command strobe already decoded for this channel
//   cmd_op         opcode (kt_pkg OP_*)
//   cmd_data       operand for loads / direction
//   tick           1 Hz tick pulse
//   err_c          combinational: strobed command is rejected in this state
//   cnt_min        current minutes (binary)
//   cnt_sec        current seconds (binary)
//   running        channel is in RUN
//   alarm          channel is in ALARM
module kt_channel
   import kt_pkg::*;
#(
   parameter int unsigned MAX_MIN    = 59,
   parameter int unsigned ALARM_SECS = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   input  logic [2:0] cmd_op,
   input  logic [6:0] cmd_data,
   input  logic       tick,
   output logic       err_c,
   output logic [6:0] cnt_min,
   output logic [6:0] cnt_sec,
   output logic       running,
   output logic       alarm
);

   localparam logic [6:0] MIN_LIM = 7'(MAX_MIN);

   kt_state_t  state;
   logic       dir_up;
   logic [6:0] acnt;
   logic       accept;

   // Legality of the strobed command in the current state
   always_comb begin
      accept = 1'b0;
      err_c  = 1'b0;
      if (cmd_valid) begin
         case (cmd_op)
            OP_LD_MIN, OP_LD_SEC, OP_SET_DIR:
               accept = (state == ST_IDLE) || (state == ST_PAUSED);
            OP_START:  accept = (state == ST_IDLE);
            OP_PAUSE:  accept = (state == ST_RUN);
            OP_RESUME: accept = (state == ST_PAUSED);
            OP_CLEAR:  accept = 1'b1;
            default:   accept = 1'b0;
         endcase
         err_c = !accept && (cmd_op != OP_NOP);
      end
   end

   // FSM, counter and alarm timer; running/alarm are updated with the state.
   // A strobe in the same clk as a tick wins and the tick is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         cnt_min <= '0;
         cnt_sec <= '0;
         dir_up  <= 1'b0;
         acnt    <= '0;
         running <= 1'b0;
         alarm   <= 1'b0;
      end else if (cmd_valid) begin
         if (accept) begin
            case (cmd_op)
               OP_LD_MIN:  cnt_min <= (cmd_data > MIN_LIM) ? MIN_LIM : cmd_data;
               OP_LD_SEC:  cnt_sec <= (cmd_data > SEC_MAX) ? SEC_MAX : cmd_data;
               OP_SET_DIR: dir_up  <= cmd_data[0];
               OP_START, OP_RESUME: begin
                  state   <= ST_RUN;
                  running <= 1'b1;
               end
               OP_PAUSE: begin
                  state   <= ST_PAUSED;
                  running <= 1'b0;
               end
               OP_CLEAR: begin
                  state   <= ST_IDLE;
                  running <= 1'b0;
                  alarm   <= 1'b0;
                  cnt_min <= '0;
                  cnt_sec <= '0;
                  acnt    <= '0;
               end
               default: ;
            endcase
         end
      end else if (tick) begin
         case (state)
            ST_RUN: begin
               if (dir_up) begin
                  if (cnt_sec != SEC_MAX) begin
                     cnt_sec <= cnt_sec + 7'd1;
                  end else begin
                     cnt_sec <= '0;
                     cnt_min <= (cnt_min >= MIN_LIM) ? 7'd0 : cnt_min + 7'd1;
                  end
               end else if (cnt_sec != 7'd0) begin
                  cnt_sec <= cnt_sec - 7'd1;
               end else if (cnt_min != 7'd0) begin
                  cnt_sec <= SEC_MAX;
                  cnt_min <= cnt_min - 7'd1;
               end else begin
                  // Expired: this entering tick is not counted by the alarm timer
                  state   <= ST_ALARM;
                  running <= 1'b0;
                  alarm   <= 1'b1;
                  acnt    <= '0;
               end
            end
            ST_ALARM: begin
               if (ALARM_SECS != 0) begin
                  if (acnt == 7'(ALARM_SECS - 1)) begin
                     state   <= ST_IDLE;
                     alarm   <= 1'b0;
                     acnt    <= '0;
                     cnt_min <= '0;
                     cnt_sec <= '0;
                  end else begin
                     acnt <= acnt + 7'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/kitchen_timer_multi.sv
// N-channel kitchen timer with command port and BCD display of one channel.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   tick_1hz            one-clk pulse per second
//   cmd_valid/ch/op/data command port, one command per clk
//   cmd_err             1-clk pulse the clk after a rejected command
//   disp_sel            channel shown on the digits (out of range -> 00:00)
//   min_1,min_0         BCD minutes tens/units
//   sec_1,sec_0         BCD seconds tens/units
//   running, alarm      per-channel status
module kitchen_timer_multi
   import kt_pkg::*;
#(
   parameter int unsigned N_CH       = 4,
   parameter int unsigned MAX_MIN    = 59,
   parameter int unsigned ALARM_SECS = 10,
   localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            tick_1hz,
   input  logic            cmd_valid,
   input  logic [CH_W-1:0] cmd_ch,
   input  logic [2:0]      cmd_op,
   input  logic [6:0]      cmd_data,
   output logic            cmd_err,
   input  logic [CH_W-1:0] disp_sel,
   output logic [3:0]      min_1,
   output logic [3:0]      min_0,
   output logic [3:0]      sec_1,
   output logic [3:0]      sec_0,
   output logic [N_CH-1:0] running,
   output logic [N_CH-1:0] alarm
);

   logic [N_CH-1:0] ch_sel;
   logic [N_CH-1:0] ch_err;
   logic [6:0]      ch_min [N_CH];
   logic [6:0]      ch_sec [N_CH];
   logic            bad_ch;
   logic [6:0]      dmin;
   logic [6:0]      dsec;

   assign bad_ch = (32'(cmd_ch) >= N_CH);

   // Per-channel command decode and channel instances
   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ch_sel[gi] = cmd_valid && (cmd_ch == CH_W'(gi));

      kt_channel #(
         .MAX_MIN    (MAX_MIN),
         .ALARM_SECS (ALARM_SECS)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .cmd_valid (ch_sel[gi]),
         .cmd_op    (cmd_op),
         .cmd_data  (cmd_data),
         .tick      (tick_1hz),
         .err_c     (ch_err[gi]),
         .cnt_min   (ch_min[gi]),
         .cnt_sec   (ch_sec[gi]),
         .running   (running[gi]),
         .alarm     (alarm[gi])
      );
   end

   // Display mux; unmatched selector leaves 00:00
   always_comb begin
      dmin = '0;
      dsec = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (disp_sel == CH_W'(k)) begin
            dmin = ch_min[k];
            dsec = ch_sec[k];
         end
      end
   end

   // Registered error pulse and BCD digits
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_err <= 1'b0;
         min_1   <= '0;
         min_0   <= '0;
         sec_1   <= '0;
         sec_0   <= '0;
      end else begin
         cmd_err <= cmd_valid && (cmd_op != OP_NOP) && (bad_ch || (|ch_err));
         min_1   <= 4'(dmin / 7'd10);
         min_0   <= 4'(dmin % 7'd10);
         sec_1   <= 4'(dsec / 7'd10);
         sec_0   <= 4'(dsec % 7'd10);
      end
   end

endmodule
